npu_result_reader: RTL and testbench

Host-side drain engine for the NPU output FIFO. It pulls the result byte stream out of the core through the FIFO read port, reassembles each pair of bytes into a 16-bit signed neuron output, and presents the words on a valid/ready interface with their neuron index. Over each frame it tracks the arg-max, so the classification can be checked against the core's comparator output. It sits between the NPU core's `DATA_OUT`/`RD_EN`/`EMPTY` pins and the host-side consumer.

---
 rtl/npu_pkg.sv | 21 ++
 rtl/npu_argmax_tracker.sv | 52 +++++
 rtl/npu_result_reader.sv | 147 ++++++++++++++
 tb/tb_npu_result_reader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU result reader.
package npu_pkg;

    localparam int NPU_BYTE_W = 8;
    localparam int NPU_WORD_W = 16;

    // Most negative 16-bit value: any real neuron output replaces it
    // unless the output is also 0x8000.
    localparam logic [NPU_WORD_W-1:0] NPU_MAX_INIT = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_CAP_LO  = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_CAP_HI  = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DONE    = 3'd6
    } rdr_state_t;

endpackage

// File: rtl/npu_argmax_tracker.sv
// Running signed arg-max over a frame. Strict greater-than, so on ties
// the earliest index is kept.
module npu_argmax_tracker
    import npu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  update_i,
    input  logic [NPU_WORD_W-1:0] value_i,
    input  logic [7:0]            index_i,
    output logic [NPU_WORD_W-1:0] max_value_o,
    output logic [7:0]            max_index_o
);

    logic [NPU_WORD_W-1:0] max_value_q, max_value_d;
    logic [7:0]            max_index_q, max_index_d;
    logic                  greater_s;

    assign greater_s = $signed(value_i) > $signed(max_value_q);

    // Next maximum: clear at frame start, replace only on a strictly larger value.
    always_comb begin
        max_value_d = max_value_q;
        max_index_d = max_index_q;
        if (clear_i) begin
            max_value_d = NPU_MAX_INIT;
            max_index_d = 8'd0;
        end else if (update_i && greater_s) begin
            max_value_d = value_i;
            max_index_d = index_i;
        end else begin
            max_value_d = max_value_q;
            max_index_d = max_index_q;
        end
    end

    // Maximum registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_value_q <= NPU_MAX_INIT;
            max_index_q <= 8'd0;
        end else begin
            max_value_q <= max_value_d;
            max_index_q <= max_index_d;
        end
    end

    assign max_value_o = max_value_q;
    assign max_index_o = max_index_q;

endmodule

// File: rtl/npu_result_reader.sv
// Drains the NPU output FIFO: pairs bytes (low first) into signed 16-bit
// words, presents them on valid/ready with their index, and tracks the
// frame arg-max. A FIFO stall longer than TIMEOUT aborts with a sticky ERR.
module npu_result_reader
    import npu_pkg::*;
#(
    parameter int NUM_WORDS = 10,
    parameter int TIMEOUT   = 1023
) (
    input  logic                  CLKEXT,
    input  logic                  RST,
    input  logic                  START,
    input  logic [NPU_BYTE_W-1:0] FIFO_DATA,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_RD_EN,
    output logic [NPU_WORD_W-1:0] WORD_OUT,
    output logic [7:0]            WORD_IDX,
    output logic                  WORD_VALID,
    input  logic                  WORD_READY,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic [NPU_WORD_W-1:0] MAX_VALUE,
    output logic [7:0]            MAX_INDEX,
    output logic                  ERR
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    rdr_state_t            state_q, state_d;
    logic [NPU_BYTE_W-1:0] lo_q, lo_d;
    logic [NPU_WORD_W-1:0] word_q, word_d;
    logic [7:0]            idx_q, idx_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  err_q, err_d;
    logic                  valid_q, busy_q, done_q;

    logic rd_en_s, handshake_s, clear_s, last_s, timeout_s;

    // A read is only ever issued from a request state with data available.
    assign rd_en_s     = ((state_q == ST_REQ_LO) || (state_q == ST_REQ_HI)) && !FIFO_EMPTY;
    assign handshake_s = valid_q && WORD_READY;
    assign clear_s     = (state_q == ST_IDLE) && START;
    assign last_s      = (idx_q == 8'(NUM_WORDS - 1));
    assign timeout_s   = (TIMEOUT != 32'sd0) && ((32'(wait_q) + 32'd1) >= 32'(TIMEOUT));

    // Next-state logic; wait counter defaults to zero so any state change restarts it.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        word_d  = word_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wait_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    idx_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = ST_REQ_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ_LO, ST_REQ_HI: begin
                if (rd_en_s) begin
                    state_d = (state_q == ST_REQ_LO) ? ST_CAP_LO : ST_CAP_HI;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_CAP_LO: begin
                lo_d    = FIFO_DATA;
                state_d = ST_REQ_HI;
            end
            ST_CAP_HI: begin
                word_d  = {FIFO_DATA, lo_q};
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (handshake_s) begin
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_REQ_LO;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered status outputs derived from the next state.
    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            word_q  <= '0;
            idx_q   <= 8'd0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            valid_q <= (state_d == ST_PRESENT);
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    npu_argmax_tracker u_argmax (
        .clk_i       (CLKEXT),
        .rst_i       (RST),
        .clear_i     (clear_s),
        .update_i    (handshake_s),
        .value_i     (word_q),
        .index_i     (idx_q),
        .max_value_o (MAX_VALUE),
        .max_index_o (MAX_INDEX)
    );

    assign FIFO_RD_EN = rd_en_s;
    assign WORD_OUT   = word_q;
    assign WORD_IDX   = idx_q;
    assign WORD_VALID = valid_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// Bench for npu_result_reader: two instances (2-word and 10-word frames)
// fed from byte-FIFO models with one-cycle read latency.
module tb_npu_result_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start  [2];
    logic        ready  [2];
    logic        hold   [2];
    logic [7:0]  fdata  [2];
    logic        fempty [2];
    logic        rd_en  [2];
    logic [15:0] word_o [2];
    logic [7:0]  idx_o  [2];
    logic        valid_o[2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [15:0] maxv_o [2];
    logic [7:0]  maxi_o [2];
    logic        err_o  [2];

    // FIFO models
    logic [7:0] fmem [2][0:255];
    logic [7:0] wp [2] = '{8'd0, 8'd0};
    logic [7:0] rp [2] = '{8'd0, 8'd0};

    assign fempty[0] = hold[0] | (wp[0] == rp[0]);
    assign fempty[1] = hold[1] | (wp[1] == rp[1]);

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rd_en[g]) begin
                fdata[g] <= fmem[g][rp[g]];
                rp[g]    <= rp[g] + 8'd1;
            end
        end
    end

    npu_result_reader #(.NUM_WORDS(2), .TIMEOUT(1023)) u_dut2 (
        .CLKEXT(clk), .RST(rst), .START(start[0]), .FIFO_DATA(fdata[0]),
        .FIFO_EMPTY(fempty[0]), .FIFO_RD_EN(rd_en[0]), .WORD_OUT(word_o[0]),
        .WORD_IDX(idx_o[0]), .WORD_VALID(valid_o[0]), .WORD_READY(ready[0]),
        .BUSY(busy_o[0]), .FRAME_DONE(done_o[0]), .MAX_VALUE(maxv_o[0]),
        .MAX_INDEX(maxi_o[0]), .ERR(err_o[0]));

    npu_result_reader #(.NUM_WORDS(10), .TIMEOUT(1023)) u_dut10 (
        .CLKEXT(clk), .RST(rst), .START(start[1]), .FIFO_DATA(fdata[1]),
        .FIFO_EMPTY(fempty[1]), .FIFO_RD_EN(rd_en[1]), .WORD_OUT(word_o[1]),
        .WORD_IDX(idx_o[1]), .WORD_VALID(valid_o[1]), .WORD_READY(ready[1]),
        .BUSY(busy_o[1]), .FRAME_DONE(done_o[1]), .MAX_VALUE(maxv_o[1]),
        .MAX_INDEX(maxi_o[1]), .ERR(err_o[1]));

    // Reference model state
    logic [15:0] fw [2][0:9];
    int fr_idx   [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    logic pv [2] = '{1'b0, 1'b0};
    logic pr [2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    function automatic int nw(input int g);
        return (g == 0) ? 2 : 10;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the frame model.
    task automatic monitor();
        logic [15:0] best;
        int          bi;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                pv[g] = 1'b0;
                pr[g] = 1'b0;
            end else begin
                if (rd_en[g]) chk("rd_en_while_empty", {31'd0, fempty[g]}, 32'd0);
                if (pv[g] && !pr[g]) chk("valid_dropped", {31'd0, valid_o[g]}, 32'd1);
                if (start[g] && !busy_o[g] && !done_o[g]) fr_idx[g] = 0;
                if (valid_o[g]) begin
                    if (fr_idx[g] >= nw(g)) begin
                        chk("extra_word", fr_idx[g], nw(g) - 1);
                    end else begin
                        chk("word_out", {16'd0, word_o[g]}, {16'd0, fw[g][fr_idx[g]]});
                        chk("word_idx", {24'd0, idx_o[g]}, fr_idx[g]);
                    end
                    if (ready[g]) fr_idx[g]++;
                end
                if (done_o[g]) begin
                    best = fw[g][0];
                    bi   = 0;
                    for (int i = 1; i < nw(g); i++) begin
                        if ($signed(fw[g][i]) > $signed(best)) begin
                            best = fw[g][i];
                            bi   = i;
                        end
                    end
                    chk("model_max_value", {16'd0, maxv_o[g]}, {16'd0, best});
                    chk("model_max_index", {24'd0, maxi_o[g]}, bi);
                    chk("words_in_frame", fr_idx[g], nw(g));
                    done_cnt[g]++;
                end
                pv[g] = valid_o[g];
                pr[g] = ready[g];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input int g, input logic [7:0] b);
        fmem[g][wp[g]] = b;
        wp[g] = wp[g] + 8'd1;
    endtask

    task automatic push_frame(input int g);
        for (int i = 0; i < nw(g); i++) begin
            push_byte(g, fw[g][i][7:0]);
            push_byte(g, fw[g][i][15:8]);
        end
    endtask

    task automatic start_frame(input int g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int bound, output int lat);
        int c0;
        c0  = done_cnt[g];
        lat = 0;
        while (done_cnt[g] == c0 && lat < bound) begin
            tick();
            lat++;
        end
        if (done_cnt[g] == c0) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input int g);
        chk("rst_rd_en",  {31'd0, rd_en[g]},   32'd0);
        chk("rst_word",   {16'd0, word_o[g]},  32'd0);
        chk("rst_idx",    {24'd0, idx_o[g]},   32'd0);
        chk("rst_valid",  {31'd0, valid_o[g]}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o[g]},  32'd0);
        chk("rst_done",   {31'd0, done_o[g]},  32'd0);
        chk("rst_maxv",   {16'd0, maxv_o[g]},  32'h8000);
        chk("rst_maxi",   {24'd0, maxi_o[g]},  32'd0);
        chk("rst_err",    {31'd0, err_o[g]},   32'd0);
    endtask

    initial begin
        int lat;
        int n;
        int d0;
        logic [15:0] neg_words [10];
        logic [15:0] mix_words [10];
        logic [15:0] t8_words  [10];
        mix_words = '{16'hFFFB, 16'h0007, 16'h0007, 16'h0003, 16'hFF9C,
                      16'h0000, 16'h0006, 16'h0007, 16'hFFFF, 16'h0002};
        neg_words = '{16'hFED4, 16'hFFEC, 16'hFFF9, 16'hFFF9, 16'hFE0C,
                      16'hFFF7, 16'h8000, 16'hFFF8, 16'hFF9C, 16'hFFF1};
        t8_words  = '{16'h0010, 16'h0020, 16'h0030, 16'h0400, 16'h0050,
                      16'h0060, 16'h0070, 16'h0080, 16'h0090, 16'h00A0};
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0;
            ready[g] = 1'b1;
            hold[g]  = 1'b0;
            for (int i = 0; i < 10; i++) fw[g][i] = 16'h0;
        end

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        tick();
        chk_reset(0);

        // Two-word frame, bytes 34 12 FE FF
        fw[0][0] = 16'h1234;
        fw[0][1] = 16'hFFFE;
        push_frame(0);
        start_frame(0);
        chk("busy_after_start", {31'd0, busy_o[0]}, 32'd1);
        wait_done(0, 100, lat);
        chk("latency_nw2", lat, 32'd11);
        tick();
        chk("t1_maxv", {16'd0, maxv_o[0]}, 32'h1234);
        chk("t1_maxi", {24'd0, maxi_o[0]}, 32'd0);
        chk("t1_busy_idle", {31'd0, busy_o[0]}, 32'd0);

        // Ten words with a tie at the maximum
        for (int i = 0; i < 10; i++) fw[1][i] = mix_words[i];
        push_frame(1);
        start_frame(1);
        wait_done(1, 200, lat);
        chk("latency_nw10", lat, 32'd51);
        tick();
        chk("tie_maxv", {16'd0, maxv_o[1]}, 32'h0007);
        chk("tie_maxi", {24'd0, maxi_o[1]}, 32'd1);

        // All-negative frame
        for (int i = 0; i < 10; i++) fw[1][i] = neg_words[i];
        push_frame(1);
        start_frame(1);
        wait_done(1, 200, lat);
        tick();
        chk("neg_maxv", {16'd0, maxv_o[1]}, 32'hFFF9);
        chk("neg_maxi", {24'd0, maxi_o[1]}, 32'd2);

        // Consumer back-pressure for 20 cycles
        fw[0][0] = 16'h8001;
        fw[0][1] = 16'h7FFF;
        push_frame(0);
        ready[0] = 1'b0;
        start_frame(0);
        n = 0;
        while (!valid_o[0] && n < 20) begin
            tick();
            n++;
        end
        chk("stall_valid_seen", {31'd0, valid_o[0]}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_word", {16'd0, word_o[0]}, 32'h8001);
            chk("stall_idx",  {24'd0, idx_o[0]},  32'd0);
            chk("stall_rd_en", {31'd0, rd_en[0]}, 32'd0);
        end
        ready[0] = 1'b1;
        wait_done(0, 100, lat);
        tick();
        chk("stall_maxv", {16'd0, maxv_o[0]}, 32'h7FFF);
        chk("stall_maxi", {24'd0, maxi_o[0]}, 32'd1);

        // FIFO empty between the low and high byte for 50 cycles
        fw[0][0] = 16'h00AB;
        fw[0][1] = 16'hFF00;
        push_frame(0);
        start_frame(0);
        tick();
        hold[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("gap_rd_en", {31'd0, rd_en[0]}, 32'd0);
            chk("gap_busy",  {31'd0, busy_o[0]}, 32'd1);
        end
        chk("gap_no_err", {31'd0, err_o[0]}, 32'd0);
        hold[0] = 1'b0;
        wait_done(0, 100, lat);
        tick();
        chk("gap_maxv", {16'd0, maxv_o[0]}, 32'h00AB);
        chk("gap_maxi", {24'd0, maxi_o[0]}, 32'd0);

        // Timeout with only the low byte ever arriving
        d0 = done_cnt[0];
        push_byte(0, 8'h55);
        start_frame(0);
        tick();
        n = 0;
        while (!err_o[0] && n < 1100) begin
            tick();
            n++;
        end
        chk("timeout_err", {31'd0, err_o[0]}, 32'd1);
        chk("timeout_not_early", {31'd0, (n >= 1000)}, 32'd1);
        chk("timeout_busy", {31'd0, busy_o[0]}, 32'd0);
        tick(); tick();
        chk("timeout_no_done", done_cnt[0], d0);
        chk("err_sticky", {31'd0, err_o[0]}, 32'd1);

        // Reset mid-word, then a fresh frame
        fw[0][0] = 16'h0102;
        fw[0][1] = 16'h0304;
        push_frame(0);
        start_frame(0);
        chk("restart_clears_err", {31'd0, err_o[0]}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy_o[0]}, 32'd0);
        tick(); tick();
        chk_reset(0);
        rst = 1'b0;
        tick();
        wp[0] = rp[0];
        fw[0][0] = 16'h4000;
        fw[0][1] = 16'h4000;
        push_frame(0);
        start_frame(0);
        chk("new_frame_maxv", {16'd0, maxv_o[0]}, 32'h8000);
        chk("new_frame_idx",  {24'd0, idx_o[0]},  32'd0);
        wait_done(0, 100, lat);
        chk("post_rst_latency", lat, 32'd11);
        tick();
        chk("post_rst_maxv", {16'd0, maxv_o[0]}, 32'h4000);
        chk("post_rst_maxi", {24'd0, maxi_o[0]}, 32'd0);

        // START pulses while busy are ignored
        d0 = done_cnt[1];
        for (int i = 0; i < 10; i++) fw[1][i] = t8_words[i];
        push_frame(1);
        start_frame(1);
        tick(); tick(); tick();
        start[1] = 1'b1;
        tick(); tick();
        start[1] = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        wait_done(1, 200, lat);
        for (int i = 0; i < 60; i++) tick();
        chk("busy_start_one_done", done_cnt[1] - d0, 32'd1);
        chk("busy_start_idle", {31'd0, busy_o[1]}, 32'd0);
        chk("busy_start_err", {31'd0, err_o[1]}, 32'd0);
        chk("busy_start_maxv", {16'd0, maxv_o[1]}, 32'h0400);
        chk("busy_start_maxi", {24'd0, maxi_o[1]}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
